// File: rtl/front_panel_keys.sv
// front_panel_keys: synchronizes and debounces front-panel switches and keys, turns key presses into one-clock command pulses and steps the display select
module front_panel_keys #(
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:11] sr_raw,
   input  logic        halt_raw,
   input  logic        sstep_raw,
   input  logic [6:0]  key_raw,
   input  logic        run_ff,
   output logic [0:11] sr,
   output logic        halt_sw,
   output logic        sstep_sw,
   output logic        clear_p,
   output logic        addr_load_p,
   output logic        extd_load_p,
   output logic        dep_p,
   output logic        exam_p,
   output logic        cont_p,
   output logic [2:0]  dsel,
   output logic        sw_active
);
   localparam int N  = 21;
   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {LOCKOUT, IDLE, HELD} state_t;

   state_t          state, nxt;
   logic [N-1:0]    s1, s2, deb;
   logic [3:0]      cnt [N];
   logic [PW-1:0]   pre;
   logic            tick, anydown, raw_held, active_nxt;
   logic [6:0]      keys, win, fire;

   assign tick     = pre == PW'(TICK_DIV - 1);
   assign sr       = deb[20:9];
   assign halt_sw  = deb[8];
   assign sstep_sw = deb[7];
   assign keys     = deb[6:0];
   assign anydown  = |keys;
   // a key still physically held (synced, not yet debounced) keeps the lockout engaged
   assign raw_held = |s2[6:0];

   // two-flop synchronizer for every raw input, left unreset so held levels survive reset
   always_ff @(posedge clk) begin
      s1 <= {sr_raw, halt_raw, sstep_raw, key_raw};
      s2 <= s1;
   end

   // debounce sample prescaler
   always_ff @(posedge clk) begin
      if (!reset) pre <= '0;
      else        pre <= tick ? '0 : pre + 1'b1;
   end

   // per-input debounce: accept a new level after STABLE_TICKS consecutive disagreeing ticks
   always_ff @(posedge clk) begin
      if (!reset) begin
         deb <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else if (tick) begin
         for (int i = 0; i < N; i++)
            if (s2[i] == deb[i]) cnt[i] <= '0;
            else if (cnt[i] == 4'(STABLE_TICKS - 1)) begin
               deb[i] <= s2[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + 4'd1;
      end
   end

   // key FSM state register
   always_ff @(posedge clk) begin
      if (!reset) state <= LOCKOUT;
      else        state <= nxt;
   end

   // key FSM next state
   always_comb begin
      nxt = state;
      if (state == LOCKOUT) nxt = (anydown || raw_held) ? LOCKOUT : IDLE;
      else                  nxt = anydown ? HELD : IDLE;
   end

   // winner selection and permission check; higher key index has priority
   always_comb begin
      win = '0;
      for (int i = 0; i < 7; i++) win = keys[i] ? 7'(1 << i) : win;
      fire       = (state == IDLE && (win[0] || !run_ff)) ? win : '0;
      active_nxt = nxt != IDLE;
   end

   // registered command pulses, activity flag and display-select stepping
   always_ff @(posedge clk) begin
      if (!reset) begin
         {clear_p, addr_load_p, extd_load_p, dep_p, exam_p, cont_p} <= '0;
         sw_active <= 1'b0;
         dsel      <= '0;
      end else begin
         {clear_p, addr_load_p, extd_load_p, dep_p, exam_p, cont_p} <= fire[6:1];
         sw_active <= active_nxt;
         if (fire[0]) dsel <= (dsel >= 3'd5) ? 3'd0 : dsel + 3'd1;
      end
   end
endmodule

// File: tb/tb_front_panel_keys.sv
// tb_front_panel_keys: directed self-checking bench for front_panel_keys
module tb_front_panel_keys;
   logic        clk = 0, reset = 0;
   logic [0:11] sr_raw = '0;
   logic        halt_raw = 0, sstep_raw = 0, run_ff = 0;
   logic [6:0]  key_raw = '0;
   logic [0:11] sr;
   logic        halt_sw, sstep_sw, clear_p, addr_load_p, extd_load_p, dep_p, exam_p, cont_p, sw_active;
   logic [2:0]  dsel;
   logic [5:0]  pv;
   int          checks = 0, failures = 0, multi = 0;
   int          pc [6];
   int          b  [6];

   front_panel_keys #(.TICK_DIV(4), .STABLE_TICKS(3)) dut (
      .clk(clk), .reset(reset), .sr_raw(sr_raw), .halt_raw(halt_raw), .sstep_raw(sstep_raw),
      .key_raw(key_raw), .run_ff(run_ff), .sr(sr), .halt_sw(halt_sw), .sstep_sw(sstep_sw),
      .clear_p(clear_p), .addr_load_p(addr_load_p), .extd_load_p(extd_load_p), .dep_p(dep_p),
      .exam_p(exam_p), .cont_p(cont_p), .dsel(dsel), .sw_active(sw_active)
   );

   always #5 clk = ~clk;

   assign pv = {cont_p, exam_p, dep_p, extd_load_p, addr_load_p, clear_p};

   initial for (int i = 0; i < 6; i++) pc[i] = 0;

   // count pulse cycles per command and cycles with more than one pulse
   always @(negedge clk) begin
      for (int i = 0; i < 6; i++) if (pv[i]) pc[i]++;
      if ($countones(pv) > 1) multi++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [6:0] k, input int ticks);
      key_raw = k;
      cyc(ticks * 4);
      key_raw = '0;
      cyc(40);
   endtask

   initial begin
      // reset with DEP held
      key_raw = 7'b0001000;
      cyc(10);
      chk("rst_sr", 32'(sr), 0);
      chk("rst_pulses", 32'(pv), 0);
      chk("rst_dsel", 32'(dsel), 0);
      chk("rst_active", 32'(sw_active), 0);
      reset = 1;
      cyc(80);
      chk("held_no_pulse", 32'(pc[3]), 0);
      chk("held_active", 32'(sw_active), 1);
      key_raw = '0;
      cyc(40);
      chk("release_idle", 32'(sw_active), 0);
      chk("release_no_pulse", 32'(pc[3]), 0);
      // re-press DEP
      key_raw = 7'b0001000;
      cyc(60);
      chk("dep_active", 32'(sw_active), 1);
      cyc(20);
      key_raw = '0;
      cyc(40);
      chk("dep_once", 32'(pc[3]), 1);
      chk("dep_only", 32'(pc[0] + pc[1] + pc[2] + pc[4] + pc[5]), 0);
      // glitch on sr_raw[0]
      sr_raw = 12'o4000;
      cyc(8);
      sr_raw = '0;
      cyc(24);
      chk("glitch", 32'(sr), 0);
      sr_raw = 12'o4000;
      cyc(8);
      chk("two_ticks", 32'(sr), 0);
      cyc(8);
      chk("three_ticks", 32'(sr), 32'o4000);
      sr_raw = 12'o1234;
      halt_raw = 1;
      sstep_raw = 1;
      cyc(24);
      chk("sr_pattern", 32'(sr), 32'o1234);
      chk("halt_sw", 32'(halt_sw), 1);
      chk("sstep_sw", 32'(sstep_sw), 1);
      // simultaneous DEP+EXAM
      b = pc;
      key_raw = 7'b0001100;
      cyc(40);
      key_raw = 7'b0001000;
      cyc(40);
      key_raw = 7'b0001100;
      cyc(40);
      chk("sim_dep", 32'(pc[3] - b[3]), 1);
      chk("sim_no_exam", 32'(pc[4] - b[4]), 0);
      key_raw = '0;
      cyc(40);
      press(7'b0000100, 6);
      chk("exam_again", 32'(pc[4] - b[4]), 1);
      // run_ff blocks everything but SEL_STEP
      b = pc;
      run_ff = 1;
      key_raw = 7'b0000100;
      cyc(40);
      chk("run_active", 32'(sw_active), 1);
      key_raw = '0;
      cyc(40);
      press(7'b0000010, 6);
      chk("run_blocked", 32'(pc[4] - b[4] + pc[5] - b[5]), 0);
      run_ff = 0;
      press(7'b0000010, 6);
      chk("cont_once", 32'(pc[5] - b[5]), 1);
      // all keys at once: CLEAR wins
      b = pc;
      press(7'b1111111, 6);
      chk("clear_prio", 32'(pc[0] - b[0]), 1);
      chk("clear_only", 32'(pc[1] - b[1] + pc[2] - b[2] + pc[3] - b[3] + pc[4] - b[4] + pc[5] - b[5]), 0);
      // SEL_STEP sequence from reset
      reset = 0;
      cyc(4);
      reset = 1;
      cyc(4);
      for (int i = 0; i < 7; i++) begin
         press(7'b0000001, 6);
         chk($sformatf("dsel_%0d", i), 32'(dsel), (i + 1) % 6);
      end
      run_ff = 1;
      press(7'b0000001, 6);
      chk("dsel_run", 32'(dsel), 2);
      run_ff = 0;
      // reset during dep_p
      b = pc;
      key_raw = 7'b0001000;
      for (int i = 0; i < 200 && !dep_p; i++) @(negedge clk);
      chk("dep_seen", 32'(dep_p), 1);
      reset = 0;
      cyc(1);
      chk("rst_mid_dep", 32'(dep_p), 0);
      chk("rst_mid_dsel", 32'(dsel), 0);
      cyc(2);
      reset = 1;
      cyc(60);
      chk("lockout_active", 32'(sw_active), 1);
      chk("lockout_no_repulse", 32'(pc[3] - b[3]), 1);
      key_raw = '0;
      cyc(40);
      chk("lockout_exit", 32'(sw_active), 0);
      chk("one_hot", 32'(multi), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
